// File: rtl/mem_bist_controller.sv
// March C- self-test sequencer for a level-sensitive word memory. It drives every memory
// pin, checks each read against the expected background and reports the test outcome.
module mem_bist_controller #(
  parameter int wordSize   = 4,
  parameter int numWords   = 64,
  parameter bit stopOnFail = 1'b0
) (
  input  logic                        clk,
  input  logic                        rstN,
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  output logic                        pass,
  output logic [7:0]                  errCount,
  output logic [$clog2(numWords)-1:0] failAddr,
  output logic [2:0]                  failElement,
  output logic                        memEnable,
  output logic                        memReadWrite,
  output logic [$clog2(numWords)-1:0] memAddress,
  output logic [wordSize-1:0]         memDataIn,
  input  logic [wordSize-1:0]         memDataOut
);

  localparam int              AW        = $clog2(numWords);
  localparam logic [AW-1:0]   ADDR_LAST = AW'(numWords - 1);
  localparam logic [2:0]      ELEM_LAST = 3'd5;

  // Handshake: start is a level request honoured only in IDLE or DONE; busy covers the
  // whole run and done holds from the final edge until the next accepted start. Each
  // memory op is a SETUP cycle (enable low, pins settle) then an ACCESS cycle (enable high).
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [2:0]      elem_q, elem_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            op_q, op_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic [7:0]      err_q, err_d;
  logic [AW-1:0]   fail_addr_q, fail_addr_d;
  logic [2:0]      fail_elem_q, fail_elem_d;
  logic            mem_en_q, mem_en_d;
  logic            mem_rw_q, mem_rw_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [wordSize-1:0] mem_wdata_q, mem_wdata_d;

  logic            miscmp;
  logic            test_end;
  logic [2:0]      nxt_elem;
  logic [AW-1:0]   nxt_addr;
  logic            nxt_op;

  // Elements 3 and 4 walk the address space downwards.
  function automatic logic elem_down(input logic [2:0] e);
    return (e == 3'd3) || (e == 3'd4);
  endfunction

  function automatic logic op_is_read(input logic [2:0] e, input logic o);
    return (e != 3'd0) && !o;
  endfunction

  function automatic logic op_is_last(input logic [2:0] e, input logic o);
    return ((e == 3'd0) || (e == 3'd5)) ? 1'b1 : o;
  endfunction

  // Elements 1/3 read zeros then write ones; elements 2/4 read ones then write zeros.
  function automatic logic op_data_ones(input logic [2:0] e, input logic o);
    return (((e == 3'd1) || (e == 3'd3)) && o) || (((e == 3'd2) || (e == 3'd4)) && !o);
  endfunction

  always_comb begin
    nxt_elem = elem_q;
    nxt_addr = addr_q;
    nxt_op   = 1'b0;
    test_end = 1'b0;
    if (!op_is_last(elem_q, op_q)) begin
      nxt_op = 1'b1;
    end else if (addr_q == (elem_down(elem_q) ? '0 : ADDR_LAST)) begin
      if (elem_q == ELEM_LAST) begin
        test_end = 1'b1;
      end else begin
        nxt_elem = elem_q + 3'd1;
        nxt_addr = elem_down(elem_q + 3'd1) ? ADDR_LAST : '0;
      end
    end else begin
      nxt_addr = elem_down(elem_q) ? (addr_q - 1'b1) : (addr_q + 1'b1);
    end
  end

  // memDataIn always carries the background, so it doubles as the read expectation.
  assign miscmp = (state_q == ACCESS) && mem_rw_q && (memDataOut != mem_wdata_q);

  always_comb begin
    state_d     = state_q;
    elem_d      = elem_q;
    addr_d      = addr_q;
    op_d        = op_q;
    busy_d      = busy_q;
    done_d      = done_q;
    pass_d      = pass_q;
    err_d       = err_q;
    fail_addr_d = fail_addr_q;
    fail_elem_d = fail_elem_q;
    mem_en_d    = 1'b0;
    mem_rw_d    = mem_rw_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d     = SETUP;
          elem_d      = 3'd0;
          addr_d      = '0;
          op_d        = 1'b0;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          pass_d      = 1'b0;
          err_d       = 8'd0;
          fail_addr_d = '0;
          fail_elem_d = 3'd0;
          mem_rw_d    = 1'b0;
          mem_addr_d  = '0;
          mem_wdata_d = '0;
        end
      end
      SETUP: begin
        mem_en_d = 1'b1;
        state_d  = ACCESS;
      end
      ACCESS: begin
        if (miscmp) begin
          if (err_q != 8'hFF) err_d = err_q + 8'd1;
          if (err_q == 8'd0) begin
            fail_addr_d = addr_q;
            fail_elem_d = elem_q;
          end
        end
        if (test_end || (miscmp && stopOnFail)) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_d == 8'd0);
        end else begin
          state_d     = SETUP;
          elem_d      = nxt_elem;
          addr_d      = nxt_addr;
          op_d        = nxt_op;
          mem_addr_d  = nxt_addr;
          mem_rw_d    = op_is_read(nxt_elem, nxt_op);
          mem_wdata_d = op_data_ones(nxt_elem, nxt_op) ? '1 : '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q     <= IDLE;
      elem_q      <= 3'd0;
      addr_q      <= '0;
      op_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_q       <= 8'd0;
      fail_addr_q <= '0;
      fail_elem_q <= 3'd0;
      mem_en_q    <= 1'b0;
      mem_rw_q    <= 1'b1;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      elem_q      <= elem_d;
      addr_q      <= addr_d;
      op_q        <= op_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_q       <= err_d;
      fail_addr_q <= fail_addr_d;
      fail_elem_q <= fail_elem_d;
      mem_en_q    <= mem_en_d;
      mem_rw_q    <= mem_rw_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign errCount     = err_q;
  assign failAddr     = fail_addr_q;
  assign failElement  = fail_elem_q;
  assign memEnable    = mem_en_q;
  assign memReadWrite = mem_rw_q;
  assign memAddress   = mem_addr_q;
  assign memDataIn    = mem_wdata_q;

endmodule

// File: tb/tb_mem_bist_controller.sv
// Bench for mem_bist_controller: a run-to-completion and a stop-on-fail instance share
// start/reset, each with its own faultable memory, checked against a March C- model.
module tb_mem_bist_controller;

  localparam int WS  = 4;
  localparam int NW  = 64;
  localparam int AW  = 6;
  localparam int OPW = 1 + AW + WS;
  localparam logic [WS-1:0] DEAD_WORD = 4'b0110;

  typedef struct packed {
    logic          pass;
    logic [7:0]    err;
    logic [AW-1:0] fa;
    logic [2:0]    fe;
    logic [15:0]   cycles;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;

  logic [1:0]          busy, done, pass, mem_en, mem_rw;
  logic [1:0][7:0]     err_cnt;
  logic [1:0][AW-1:0]  fail_addr, mem_addr;
  logic [1:0][2:0]     fail_elem;
  logic [1:0][WS-1:0]  mem_din;
  logic [WS-1:0]       dout0, dout1;

  logic [WS-1:0] mem0 [NW];
  logic [WS-1:0] mem1 [NW];

  int            fault_mode = 0;  // 0 none, 1 stuck bit, 2 dead memory
  logic [AW-1:0] f_addr = '0;
  int            f_bit = 0;
  logic          f_val = 1'b0;

  logic [OPW-1:0] exp_q0[$];
  logic [OPW-1:0] exp_q1[$];
  res_t           res_q0[$];
  res_t           res_q1[$];

  int total = 0;
  int bad = 0;

  logic [1:0]          prev_en = '0, prev_done = '0, prev_busy = '0, prev_rw = '0;
  logic [1:0][AW-1:0]  prev_addr = '0;
  logic [1:0][WS-1:0]  prev_din = '0;
  int                  busy_cnt [2];

  always #5 clk = ~clk;

  mem_bist_controller #(.wordSize(WS), .numWords(NW), .stopOnFail(1'b0)) dut_run (
    .clk(clk), .rstN(rst_n), .start(start),
    .busy(busy[0]), .done(done[0]), .pass(pass[0]), .errCount(err_cnt[0]),
    .failAddr(fail_addr[0]), .failElement(fail_elem[0]),
    .memEnable(mem_en[0]), .memReadWrite(mem_rw[0]), .memAddress(mem_addr[0]),
    .memDataIn(mem_din[0]), .memDataOut(dout0)
  );

  mem_bist_controller #(.wordSize(WS), .numWords(NW), .stopOnFail(1'b1)) dut_stop (
    .clk(clk), .rstN(rst_n), .start(start),
    .busy(busy[1]), .done(done[1]), .pass(pass[1]), .errCount(err_cnt[1]),
    .failAddr(fail_addr[1]), .failElement(fail_elem[1]),
    .memEnable(mem_en[1]), .memReadWrite(mem_rw[1]), .memAddress(mem_addr[1]),
    .memDataIn(mem_din[1]), .memDataOut(dout1)
  );

  function automatic logic [WS-1:0] faulty(input logic [WS-1:0] w, input logic [AW-1:0] a,
                                           input int mode, input logic [AW-1:0] fa,
                                           input int fb, input logic fv);
    logic [WS-1:0] r;
    r = w;
    if (mode == 1 && a == fa) r[fb] = fv;
    else if (mode == 2) r = DEAD_WORD;
    return r;
  endfunction

  always_comb dout0 = faulty(mem0[mem_addr[0]], mem_addr[0], fault_mode, f_addr, f_bit, f_val);
  always_comb dout1 = faulty(mem1[mem_addr[1]], mem_addr[1], fault_mode, f_addr, f_bit, f_val);

  always @(posedge clk) begin
    if (mem_en[0] && !mem_rw[0]) mem0[mem_addr[0]] <= mem_din[0];
    if (mem_en[1] && !mem_rw[1]) mem1[mem_addr[1]] <= mem_din[1];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: walk the March C- elements over an abstract memory, queueing every op
  // and the final result the instance should report.
  task automatic model_run(input int k);
    logic [WS-1:0] m [NW];
    int errs, ops, a, nops;
    logic [AW-1:0] fa;
    logic [2:0] fe;
    bit halted, rd;
    logic [WS-1:0] d, got;
    res_t res;
    errs = 0; ops = 0; fa = '0; fe = '0; halted = 1'b0;
    for (int i = 0; i < NW; i++) m[i] = '0;
    for (int e = 0; e < 6; e++) begin
      nops = (e == 0 || e == 5) ? 1 : 2;
      for (int j = 0; j < NW; j++) begin
        a = (e == 3 || e == 4) ? NW - 1 - j : j;
        for (int o = 0; o < nops; o++) begin
          if (!halted) begin
            rd = (e != 0 && o == 0);
            if (e == 0 || e == 5) d = '0;
            else if (e == 1 || e == 3) d = (o == 0) ? '0 : '1;
            else d = (o == 0) ? '1 : '0;
            ops++;
            if (k == 0) exp_q0.push_back({rd, AW'(a), d});
            else exp_q1.push_back({rd, AW'(a), d});
            if (!rd) m[a] = d;
            else begin
              got = faulty(m[a], AW'(a), fault_mode, f_addr, f_bit, f_val);
              if (got != d) begin
                if (errs == 0) begin fa = AW'(a); fe = 3'(e); end
                errs++;
                if (k == 1) halted = 1'b1;
              end
            end
          end
        end
      end
    end
    res.pass   = (errs == 0);
    res.err    = (errs > 255) ? 8'd255 : 8'(errs);
    res.fa     = fa;
    res.fe     = fe;
    res.cycles = 16'(2 * ops);
    if (k == 0) res_q0.push_back(res); else res_q1.push_back(res);
  endtask

  task automatic monitor_step();
    logic [OPW-1:0] got_op, want_op;
    res_t want;
    int qsz;
    for (int k = 0; k < 2; k++) begin
      if (mem_en[k]) begin
        check("en_back_to_back", 64'(prev_en[k]), 64'(0));
        check("setup_stable", 64'({prev_rw[k], prev_addr[k], prev_din[k]}),
              64'({mem_rw[k], mem_addr[k], mem_din[k]}));
        got_op = {mem_rw[k], mem_addr[k], mem_din[k]};
        qsz = (k == 0) ? exp_q0.size() : exp_q1.size();
        if (qsz == 0) begin
          total++; bad++;
          $display("FAIL op_unexpected inst%0d: got op %0h required none", k, got_op);
        end else begin
          if (k == 0) want_op = exp_q0.pop_front(); else want_op = exp_q1.pop_front();
          check(k == 0 ? "op_seq_run" : "op_seq_stop", 64'(got_op), 64'(want_op));
        end
      end
      if (done[k]) check("done_en_low", 64'(mem_en[k]), 64'(0));
      if (busy[k] && !prev_busy[k]) busy_cnt[k] = 1;
      else if (busy[k]) busy_cnt[k]++;
      if (done[k] && !prev_done[k]) begin
        qsz = (k == 0) ? res_q0.size() : res_q1.size();
        if (qsz == 0) begin
          total++; bad++;
          $display("FAIL result_unexpected inst%0d: got done required none", k);
        end else begin
          if (k == 0) want = res_q0.pop_front(); else want = res_q1.pop_front();
          check(k == 0 ? "pass_run" : "pass_stop", 64'(pass[k]), 64'(want.pass));
          check(k == 0 ? "err_run" : "err_stop", 64'(err_cnt[k]), 64'(want.err));
          check(k == 0 ? "fail_addr_run" : "fail_addr_stop", 64'(fail_addr[k]), 64'(want.fa));
          check(k == 0 ? "fail_elem_run" : "fail_elem_stop", 64'(fail_elem[k]), 64'(want.fe));
          check(k == 0 ? "busy_cycles_run" : "busy_cycles_stop", 64'(busy_cnt[k]),
                64'(want.cycles));
        end
      end
      prev_en[k]   = mem_en[k];
      prev_done[k] = done[k];
      prev_busy[k] = busy[k];
      prev_rw[k]   = mem_rw[k];
      prev_addr[k] = mem_addr[k];
      prev_din[k]  = mem_din[k];
    end
  endtask

  initial begin
    busy_cnt[0] = 0;
    busy_cnt[1] = 0;
    forever begin
      @(negedge clk);
      monitor_step();
    end
  end

  task automatic check_reset_vals();
    for (int k = 0; k < 2; k++) begin
      check("rst_busy", 64'(busy[k]), 64'(0));
      check("rst_done", 64'(done[k]), 64'(0));
      check("rst_pass", 64'(pass[k]), 64'(0));
      check("rst_err", 64'(err_cnt[k]), 64'(0));
      check("rst_fail_addr", 64'(fail_addr[k]), 64'(0));
      check("rst_fail_elem", 64'(fail_elem[k]), 64'(0));
      check("rst_mem_en", 64'(mem_en[k]), 64'(0));
      check("rst_mem_rw", 64'(mem_rw[k]), 64'(1));
      check("rst_mem_addr", 64'(mem_addr[k]), 64'(0));
      check("rst_mem_din", 64'(mem_din[k]), 64'(0));
    end
  endtask

  task automatic set_fault(input int mode, input int a, input int b, input logic v);
    fault_mode = mode;
    f_addr     = AW'(a);
    f_bit      = b;
    f_val      = v;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (!(done[0] && done[1]) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!(done[0] && done[1])) begin
      total++; bad++;
      $display("FAIL done_timeout: got done=%b required 11", done);
    end
    @(negedge clk);
    check("ops_left_run", 64'(exp_q0.size()), 64'(0));
    check("ops_left_stop", 64'(exp_q1.size()), 64'(0));
  endtask

  task automatic run_test(input int mode, input int a, input int b, input logic v);
    set_fault(mode, a, b, v);
    model_run(0);
    model_run(1);
    pulse_start();
    wait_done(3000);
  endtask

  initial begin
    #2_000_000;
    bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check_reset_vals();
    rst_n = 1'b1;
    @(negedge clk);

    run_test(0, 0, 0, 1'b0);
    run_test(1, 5, 0, 1'b1);

    // Restart from DONE with a fault-free memory; a second start mid-run must be ignored.
    set_fault(0, 0, 0, 1'b0);
    model_run(0);
    model_run(1);
    pulse_start();
    for (int k = 0; k < 2; k++) begin
      check("restart_done_clear", 64'(done[k]), 64'(0));
      check("restart_err_clear", 64'(err_cnt[k]), 64'(0));
      check("restart_fa_clear", 64'(fail_addr[k]), 64'(0));
      check("restart_fe_clear", 64'(fail_elem[k]), 64'(0));
      check("restart_busy", 64'(busy[k]), 64'(1));
    end
    repeat (97) @(negedge clk);
    start = 1'b1;
    repeat (20) @(negedge clk);
    start = 1'b0;
    wait_done(3000);

    for (int i = 0; i < 4; i++) begin
      run_test(1, int'($urandom_range(0, NW - 1)), int'($urandom_range(0, WS - 1)),
               1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 5)) @(negedge clk);
    end

    run_test(2, 0, 0, 1'b0);

    // Abort a run with reset part-way through, then rerun cleanly.
    set_fault(0, 0, 0, 1'b0);
    model_run(0);
    model_run(1);
    pulse_start();
    repeat (298) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_vals();
    exp_q0.delete();
    exp_q1.delete();
    res_q0.delete();
    res_q1.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_test(0, 0, 0, 1'b0);

    check("final_results_left", 64'(res_q0.size() + res_q1.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
